imem_arbiter: RTL and testbench
===============================

IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 4, meaning the number of cycles the debug port may be denied before it wins priority (legal range 1..15).
REQ-002 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, meaning asynchronous, active-high reset.
REQ-004 SHALL have port f_req, input, 1, meaning the fetch-stage read request.
REQ-005 SHALL have port f_addr, input, `InstAddrBus, meaning the fetch byte address.
REQ-006 SHALL have port f_flush, input, 1, meaning cancel the fetch response granted this cycle.
REQ-007 SHALL have port f_gnt, output, 1, meaning the fetch request is accepted this cycle.
REQ-008 SHALL have port f_rvalid, output, 1, meaning f_rdata is valid.
REQ-009 SHALL have port f_rdata, output, `InstBus, meaning the fetched instruction word.
REQ-010 SHALL have ports d_req (in, 1), d_addr (in, `InstAddrBus), d_gnt (out, 1), d_rvalid (out, 1) and d_rdata (out, `InstBus), meaning the debug/loader read port, with the same semantics as the fetch port.
REQ-011 SHALL have ports mem_ce (out, 1), mem_addr (out, `InstAddrBus) and mem_inst (in, `InstBus), meaning the single-port combinational instruction memory.

Function
REQ-012 SHALL grant at most one port per cycle; f_gnt and d_gnt are combinational from the requests and wait_cnt.
REQ-013 SHALL give fetch priority; the exception is d_req=1 with wait_cnt==MAX_WAIT, in which case debug wins.
REQ-014 SHALL keep wait_cnt, a saturating counter: +1 each cycle with d_req=1 and d_gnt=0; cleared when d_gnt=1 or d_req=0.
REQ-015 SHALL drive mem_ce=`ChipEnable and mem_addr=(granted address) when a grant is given; otherwise mem_ce=`ChipDisable and mem_addr=`ZEROWORD.
REQ-016 SHALL capture mem_inst into a response register on the grant edge, giving read latency of exactly 1 cycle: grant in cycle N -> rvalid=1 with data in cycle N+1, for one cycle only.
REQ-017 SHALL use resp_state FSM with states IDLE, RESP_F and RESP_D; the next state is RESP_F on f_gnt with f_flush=0, RESP_D on d_gnt, and IDLE otherwise.
REQ-018 SHALL assert f_rvalid only in RESP_F and d_rvalid only in RESP_D; the rdata of a port not in its RESP state SHALL read `ZEROWORD.
REQ-019 SHALL, when f_flush=1 in the f_gnt cycle, still perform the memory access but return IDLE with no f_rvalid next cycle; f_flush in any other cycle has no effect.
REQ-020 SHALL support back-to-back grants every cycle, with full throughput on either port.
REQ-021 SHALL serve simultaneous f_req and d_req with wait_cnt<MAX_WAIT by granting fetch only; the debug request stays pending and wait_cnt increments.
REQ-022 SHALL pass the address through unmodified; word indexing is done by the memory.

Reset
REQ-023 SHALL, on rst=1, immediately clear resp_state to IDLE, wait_cnt to 0 and the response register to `ZEROWORD; f_rvalid and d_rvalid SHALL be 0.
REQ-024 SHALL force f_gnt=0, d_gnt=0 and mem_ce=`ChipDisable while rst=1.
REQ-025 SHALL drop a response pending when reset hits mid-operation; no rvalid is produced after reset release for a pre-reset grant.

Structure
REQ-026 SHALL take bus widths, `ChipEnable, `ChipDisable and `ZEROWORD from the shared defines.vh; the resp_state encodings are added there as IMEM_ARB_* constants.
REQ-027 SHALL be a single flat module; the counter and FSM are not split out.

Verification
REQ-028 SHALL cover fetch only: f_req=1 at 0x0,0x4,0x8 in three consecutive cycles -> f_rvalid 1 in each following cycle, with f_rdata = mem[0..2].
REQ-029 SHALL cover contention: f_req and d_req held 1 with MAX_WAIT=4 -> fetch granted 4 cycles, d_gnt in cycle 5, fetch again in cycle 6.
REQ-030 SHALL cover flush: f_req=1 at 0x10 with f_flush=1 -> mem_ce pulses but f_rvalid stays 0 the next cycle; an unflushed grant at 0x14 the next cycle -> f_rvalid 1.
REQ-031 SHALL cover reset mid-operation: d_gnt at 0x20, then rst asserted before the next edge -> d_rvalid 0, wait_cnt 0, mem_ce disabled.
REQ-032 SHALL cover idle: no requests -> mem_ce=`ChipDisable, mem_addr=0, both rvalid 0, both rdata 0.
REQ-033 SHALL cover debug only: d_req=1 at 0x40 -> d_gnt same cycle, d_rvalid with d_rdata=mem[16] next cycle.

Source files
------------

// File: rtl/imem_arbiter_pkg.sv
// Shared widths, bus constants and response-FSM encodings for the
// instruction-memory arbiter.
package imem_arbiter_pkg;

   localparam int INST_ADDR_W = 32;
   localparam int INST_W      = 32;
   localparam int WAIT_W      = 4;

   localparam logic              CHIP_ENABLE  = 1'b1;
   localparam logic              CHIP_DISABLE = 1'b0;
   localparam logic [INST_W-1:0] ZEROWORD     = '0;

   typedef enum logic [1:0] {
      IMEM_ARB_IDLE   = 2'd0,
      IMEM_ARB_RESP_F = 2'd1,
      IMEM_ARB_RESP_D = 2'd2
   } resp_state_e;

endpackage

// File: rtl/imem_arbiter.sv
// Two-port arbiter in front of a single-port combinational instruction memory.
// Fetch has priority; the debug port wins after MAX_WAIT denied cycles.
//
// Handshake: a port holds req (and addr) until it sees gnt in the same cycle.
// A grant in cycle N yields rvalid with rdata for exactly one cycle in N+1.
// The port has no ready signal, so the response cannot be stalled.
module imem_arbiter
   import imem_arbiter_pkg::*;
#(
   parameter int MAX_WAIT = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   f_req,
   input  logic [INST_ADDR_W-1:0] f_addr,
   input  logic                   f_flush,
   output logic                   f_gnt,
   output logic                   f_rvalid,
   output logic [INST_W-1:0]      f_rdata,
   input  logic                   d_req,
   input  logic [INST_ADDR_W-1:0] d_addr,
   output logic                   d_gnt,
   output logic                   d_rvalid,
   output logic [INST_W-1:0]      d_rdata,
   output logic                   mem_ce,
   output logic [INST_ADDR_W-1:0] mem_addr,
   input  logic [INST_W-1:0]      mem_inst,
   output logic [1:0]             dbg_state_o,
   output logic [WAIT_W-1:0]      dbg_wait_cnt_o
);

   localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

   resp_state_e       state_q, state_d;
   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic [INST_W-1:0] resp_q, resp_d;
   logic              d_wins;

   // Grants stay combinational so a request is accepted in the cycle it appears.
   always_comb begin
      d_wins   = d_req && (wait_cnt_q == MAX_WAIT_C);
      f_gnt    = 1'b0;
      d_gnt    = 1'b0;
      mem_ce   = CHIP_DISABLE;
      mem_addr = ZEROWORD;
      if (!rst) begin
         f_gnt = f_req && !d_wins;
         d_gnt = d_req && (!f_req || d_wins);
      end
      if (f_gnt) begin
         mem_ce   = CHIP_ENABLE;
         mem_addr = f_addr;
      end else if (d_gnt) begin
         mem_ce   = CHIP_ENABLE;
         mem_addr = d_addr;
      end
   end

   always_comb begin
      wait_cnt_d = '0;
      if (d_req && !d_gnt) begin
         wait_cnt_d = (wait_cnt_q == '1) ? wait_cnt_q : wait_cnt_q + 1'b1;
      end
   end

   // A flushed fetch still reads memory but produces no response.
   always_comb begin
      state_d = IMEM_ARB_IDLE;
      resp_d  = resp_q;
      if (f_gnt || d_gnt) begin
         resp_d = mem_inst;
      end
      if (f_gnt && !f_flush) begin
         state_d = IMEM_ARB_RESP_F;
      end else if (d_gnt) begin
         state_d = IMEM_ARB_RESP_D;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IMEM_ARB_IDLE;
         wait_cnt_q <= '0;
         resp_q     <= ZEROWORD;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         resp_q     <= resp_d;
      end
   end

   always_comb begin
      f_rvalid = (state_q == IMEM_ARB_RESP_F);
      d_rvalid = (state_q == IMEM_ARB_RESP_D);
      f_rdata  = f_rvalid ? resp_q : ZEROWORD;
      d_rdata  = d_rvalid ? resp_q : ZEROWORD;
   end

   assign dbg_state_o    = state_q;
   assign dbg_wait_cnt_o = wait_cnt_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed table-driven bench for imem_arbiter with a combinational memory
// model whose word at index i is 0x1000_0000 + i*0x11.
module tb_imem_arbiter;
   import imem_arbiter_pkg::*;

   logic                   clk;
   logic                   rst;
   logic                   f_req, f_flush, d_req;
   logic [INST_ADDR_W-1:0] f_addr, d_addr;
   logic                   f_gnt, f_rvalid, d_gnt, d_rvalid, mem_ce;
   logic [INST_W-1:0]      f_rdata, d_rdata, mem_inst;
   logic [INST_ADDR_W-1:0] mem_addr;
   logic [1:0]             dbg_state;
   logic [WAIT_W-1:0]      dbg_wait_cnt;

   int n_checks;
   int n_fail;

   imem_arbiter #(.MAX_WAIT(4)) dut (
      .clk(clk), .rst(rst),
      .f_req(f_req), .f_addr(f_addr), .f_flush(f_flush),
      .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
      .d_req(d_req), .d_addr(d_addr),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .mem_ce(mem_ce), .mem_addr(mem_addr), .mem_inst(mem_inst),
      .dbg_state_o(dbg_state), .dbg_wait_cnt_o(dbg_wait_cnt)
   );

   // clock / memory model
   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign mem_inst = 32'h1000_0000 + {2'b00, mem_addr[31:2]} * 32'h11;

   typedef struct {
      logic        f_req;
      logic [31:0] f_addr;
      logic        f_flush;
      logic        d_req;
      logic [31:0] d_addr;
      logic        e_fg;
      logic        e_dg;
      logic        e_ce;
      logic [31:0] e_maddr;
      logic        e_frv;
      logic [31:0] e_frd;
      logic        e_drv;
      logic [31:0] e_drd;
      logic [3:0]  e_wait;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic fr, input logic [31:0] fa, input logic ff,
                        input logic dr, input logic [31:0] da);
      f_req = fr; f_addr = fa; f_flush = ff; d_req = dr; d_addr = da;
   endtask

   task automatic add(input logic fr, input logic [31:0] fa, input logic ff,
                      input logic dr, input logic [31:0] da,
                      input logic fg, input logic dg, input logic ce, input logic [31:0] ma,
                      input logic frv, input logic [31:0] frd,
                      input logic drv, input logic [31:0] drd, input logic [3:0] w);
      vec_t v;
      v.f_req = fr; v.f_addr = fa; v.f_flush = ff; v.d_req = dr; v.d_addr = da;
      v.e_fg = fg; v.e_dg = dg; v.e_ce = ce; v.e_maddr = ma;
      v.e_frv = frv; v.e_frd = frd; v.e_drv = drv; v.e_drd = drd; v.e_wait = w;
      vecs.push_back(v);
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst = 1'b1;
      drive(1'b1, 32'h4, 1'b0, 1'b1, 32'h8);

      //  fr fa       ff  dr da       fg dg ce maddr    frv frd           drv drd           wait
      add(0, 32'h00, 0, 0, 32'h00, 0, 0, 0, 32'h00, 0, 32'h0,         0, 32'h0,         0); // idle
      add(1, 32'h00, 0, 0, 32'h00, 1, 0, 1, 32'h00, 0, 32'h0,         0, 32'h0,         0); // fetch x3
      add(1, 32'h04, 0, 0, 32'h00, 1, 0, 1, 32'h04, 1, 32'h1000_0000, 0, 32'h0,         0);
      add(1, 32'h08, 0, 0, 32'h00, 1, 0, 1, 32'h08, 1, 32'h1000_0011, 0, 32'h0,         0);
      add(0, 32'h00, 0, 0, 32'h00, 0, 0, 0, 32'h00, 1, 32'h1000_0022, 0, 32'h0,         0);
      add(0, 32'h00, 0, 1, 32'h40, 0, 1, 1, 32'h40, 0, 32'h0,         0, 32'h0,         0); // debug only
      add(0, 32'h00, 0, 0, 32'h00, 0, 0, 0, 32'h00, 0, 32'h0,         1, 32'h1000_0110, 0);
      add(1, 32'h10, 1, 0, 32'h00, 1, 0, 1, 32'h10, 0, 32'h0,         0, 32'h0,         0); // flushed
      add(1, 32'h14, 0, 0, 32'h00, 1, 0, 1, 32'h14, 0, 32'h0,         0, 32'h0,         0);
      add(0, 32'h00, 0, 0, 32'h00, 0, 0, 0, 32'h00, 1, 32'h1000_0055, 0, 32'h0,         0);
      add(0, 32'h00, 1, 1, 32'h44, 0, 1, 1, 32'h44, 0, 32'h0,         0, 32'h0,         0); // stray flush
      add(0, 32'h00, 1, 0, 32'h00, 0, 0, 0, 32'h00, 0, 32'h0,         1, 32'h1000_0121, 0);
      add(1, 32'h00, 0, 1, 32'h08, 1, 0, 1, 32'h00, 0, 32'h0,         0, 32'h0,         0); // contention
      add(1, 32'h00, 0, 1, 32'h08, 1, 0, 1, 32'h00, 1, 32'h1000_0000, 0, 32'h0,         1);
      add(1, 32'h00, 0, 1, 32'h08, 1, 0, 1, 32'h00, 1, 32'h1000_0000, 0, 32'h0,         2);
      add(1, 32'h00, 0, 1, 32'h08, 1, 0, 1, 32'h00, 1, 32'h1000_0000, 0, 32'h0,         3);
      add(1, 32'h00, 0, 1, 32'h08, 0, 1, 1, 32'h08, 1, 32'h1000_0000, 0, 32'h0,         4);
      add(1, 32'h00, 0, 1, 32'h08, 1, 0, 1, 32'h00, 0, 32'h0,         1, 32'h1000_0022, 0);
      add(0, 32'h00, 0, 0, 32'h00, 0, 0, 0, 32'h00, 1, 32'h1000_0000, 0, 32'h0,         1);
      add(0, 32'h00, 0, 0, 32'h00, 0, 0, 0, 32'h00, 0, 32'h0,         0, 32'h0,         0);

      // reset: grants suppressed and state cleared while rst is high
      @(negedge clk);
      #1;
      chk("rst_f_gnt", {31'b0, f_gnt}, 32'd0);
      chk("rst_d_gnt", {31'b0, d_gnt}, 32'd0);
      chk("rst_mem_ce", {31'b0, mem_ce}, {31'b0, CHIP_DISABLE});
      chk("rst_f_rvalid", {31'b0, f_rvalid}, 32'd0);
      chk("rst_d_rvalid", {31'b0, d_rvalid}, 32'd0);
      chk("rst_wait", {28'b0, dbg_wait_cnt}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      foreach (vecs[i]) begin
         if (i != 0) @(negedge clk);
         drive(vecs[i].f_req, vecs[i].f_addr, vecs[i].f_flush, vecs[i].d_req, vecs[i].d_addr);
         #1;
         chk($sformatf("v%0d_f_gnt", i), {31'b0, f_gnt}, {31'b0, vecs[i].e_fg});
         chk($sformatf("v%0d_d_gnt", i), {31'b0, d_gnt}, {31'b0, vecs[i].e_dg});
         chk($sformatf("v%0d_mem_ce", i), {31'b0, mem_ce}, {31'b0, vecs[i].e_ce});
         chk($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].e_maddr);
         chk($sformatf("v%0d_f_rvalid", i), {31'b0, f_rvalid}, {31'b0, vecs[i].e_frv});
         chk($sformatf("v%0d_f_rdata", i), f_rdata, vecs[i].e_frd);
         chk($sformatf("v%0d_d_rvalid", i), {31'b0, d_rvalid}, {31'b0, vecs[i].e_drv});
         chk($sformatf("v%0d_d_rdata", i), d_rdata, vecs[i].e_drd);
         chk($sformatf("v%0d_wait", i), {28'b0, dbg_wait_cnt}, {28'b0, vecs[i].e_wait});
      end

      // reset mid-operation: debug grant at 0x20 with a nonzero wait count
      @(negedge clk);
      drive(1'b1, 32'h0, 1'b0, 1'b1, 32'h20);
      @(negedge clk);
      drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h20);
      #1;
      chk("mid_d_gnt", {31'b0, d_gnt}, 32'd1);
      chk("mid_mem_addr", mem_addr, 32'h20);
      chk("mid_wait_pre", {28'b0, dbg_wait_cnt}, 32'd1);
      #1;
      rst = 1'b1;
      #1;
      chk("mid_rst_d_gnt", {31'b0, d_gnt}, 32'd0);
      chk("mid_rst_mem_ce", {31'b0, mem_ce}, {31'b0, CHIP_DISABLE});
      chk("mid_rst_wait", {28'b0, dbg_wait_cnt}, 32'd0);
      @(posedge clk);
      #1;
      chk("mid_rst_d_rvalid", {31'b0, d_rvalid}, 32'd0);
      chk("mid_rst_state", {30'b0, dbg_state}, 32'd0);
      @(negedge clk);
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("post_rst_d_rvalid", {31'b0, d_rvalid}, 32'd0);
      chk("post_rst_d_rdata", d_rdata, 32'd0);
      chk("post_rst_f_rvalid", {31'b0, f_rvalid}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
